// File: rtl/mac_pkg.sv
// Shared definitions for the MAC feeder and the MMIO register slave:
// default widths and the feeder FSM state encoding.
package mac_pkg;

  localparam int unsigned MAC_WIDTH = 16;
  localparam int unsigned MAC_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous first-word-fall-through FIFO for operand pairs.
// When full, a push is accepted only together with a pop.
module mac_operand_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams buffered operand pairs into the MAC, clearing it per job and
// returning the final accumulator with a one-cycle done pulse.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_WIDTH,
  parameter int unsigned LEN_W = MAC_LEN_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] mac_x,
  output logic [WIDTH-1:0] mac_y,
  output logic             mac_reset,
  input  logic             mac_busy,
  input  logic [WIDTH-1:0] mac_acc,
  output logic             active,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned DATA_W = 2 * WIDTH;

  feed_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              done_q, done_d;

  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  assign push = in_valid && !fifo_full;
  assign pop  = (state_q == FEED) && !fifo_empty && !mac_busy
                && (cnt_q < len_q) && !reset;

  mac_operand_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({in_x, in_y}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The MAC adds x*y on every non-busy edge, so operands must be zero
  // outside pop cycles.
  assign mac_x     = pop ? head[DATA_W-1:WIDTH] : '0;
  assign mac_y     = pop ? head[WIDTH-1:0]      : '0;
  assign mac_reset = reset || (state_q == CLEAR);
  assign in_ready  = !fifo_full;
  assign active    = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = (len_q != '0) ? FEED : DONE;
      FEED: begin
        if (pop) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = DONE;
        end
      end
      DONE: begin
        result_d = mac_acc;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Initiator-side sequencer for the MMIO MAC black box: accepts operand pairs from the MMIO register front-end, buffers them, and streams them into the MAC's `x`/`y` inputs while honouring `busy`. It clears the accumulator at the start of each job, counts a programmed number of pairs, and returns the final accumulator value with a one-cycle done pulse. Sits between the MMIO register slave and the MAC instance in the CNN SoC datapath.

## Interface

Parameters:
- `WIDTH`, 16, operand and accumulator width; must match the MAC's `WIDTH`.
- `LEN_W`, 8, width of the pair-count register.
- `DEPTH`, 4, operand FIFO depth; power of two, at least 2.

Ports:
- `clock`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle job request; honoured only in IDLE.
- `cfg_len`  in  LEN_W  number of pairs in the job; sampled when `start` is honoured.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO not full.
- `in_x`, `in_y`  in  WIDTH  operand pair.
- `mac_x`, `mac_y`  out  WIDTH  to MAC `x`/`y`.
- `mac_reset`  out  1  to MAC `reset`.
- `mac_busy`  in  1  from MAC `busy`.
- `mac_acc`  in  WIDTH  from MAC `mac`.
- `active`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  WIDTH  final accumulator value; held until the next honoured `start`.

## Operation

- The MAC accumulates `x*y` on every edge where `busy` is low. The feeder therefore drives `mac_x` = `mac_y` = 0 in every cycle that is not a pop cycle. This is a hard requirement.
- FIFO push occurs when `in_valid` and `in_ready` are both high. Push is legal in any state, including IDLE (prefill) and DONE. Pop and push may occur in the same cycle.
- FSM states: IDLE, CLEAR, FEED, DONE.
  - IDLE: on `start`, latch `cfg_len` into `len_q`, zero `cnt`, and go to CLEAR.
  - CLEAR: one cycle with `mac_reset` high. Go to FEED if `len_q` ≠ 0, otherwise go to DONE.
  - FEED: a pop cycle is one where the FIFO is non-empty, `mac_busy` is low and `cnt` < `len_q`. In a pop cycle, `mac_x`/`mac_y` = FIFO head (combinational) and `cnt` increments. On the pop that makes `cnt` equal `len_q`, go to DONE.
  - DONE: one cycle. `result` ← `mac_acc`, `done` (registered) is set for the next cycle, then go to IDLE.
- `mac_reset` = `reset` OR (state == CLEAR).
- Arithmetic: no widening. `result` is `mac_acc` verbatim, i.e. modulo 2^WIDTH.
- `start` outside IDLE is ignored, with no effect on `len_q`.
- Pairs left in the FIFO after a job remain queued for the next job.

## Timing

- Reset values: state IDLE, FIFO empty, `cnt` 0, `len_q` 0, `result` 0, `done` 0, `active` 0, `in_ready` 1, `mac_x`/`mac_y` 0, `mac_reset` 1.
- `start` honoured at cycle 0 → CLEAR in cycle 1 → FEED from cycle 2.
- With the FIFO prefilled and `busy` low, pops occur in cycles 2..L+1, DONE is cycle L+2, and `done`/`result` are valid in cycle L+3.
- L = 0: DONE in cycle 2, `done` in cycle 3, `result` = 0.
- Each cycle in FEED with the FIFO empty or `mac_busy` high adds one cycle of latency.
- `mac_acc` reflects a pop-cycle pair on the edge ending that cycle. DONE therefore samples the complete sum.
- `done` is high for exactly one cycle. The earliest next `start` is honoured in the cycle `done` is high, since state is already IDLE.
- Reset mid-operation (any state): all registers return to their reset values in the next cycle, FIFO contents are discarded, and no `done` pulse is issued.

## Structure

- Shared package `mac_pkg`: FSM state enum (IDLE, CLEAR, FEED, DONE) and default `WIDTH`/`LEN_W` constants, shared with the MMIO register slave.
- One sub-module, `mac_operand_fifo`, parameterised by `DEPTH` and 2×`WIDTH` data:
  - synchronous FIFO with a registered count;
  - `full`/`empty` flags;
  - first-word-fall-through head;
  - simultaneous push/pop when full is allowed only if pop is asserted.
- The top level holds the FSM, `cnt`/`len_q`, and the `result`/`done` registers.

## Test plan

- Prefill (1,2), (3,4), (5,6); `start` with `cfg_len`=3 → pops in cycles 2–4 with `mac_x`/`mac_y` as pushed, `done` in cycle 6 with `result`=44, and `mac_x`/`mac_y` = 0 in all other cycles.
- `cfg_len`=0 with one pair queued → `done` in cycle 3 with `result`=0; the queued pair is still in the FIFO afterwards.
- Push 6 pairs while idle with `DEPTH`=4 → `in_ready` low after 4 pushes. `start` with `cfg_len`=6 → all 6 pairs are consumed, `result` = the sum of products.
- Hold `mac_busy` high for 3 cycles mid-FEED with `cfg_len`=2, pairs (2,3),(4,5) → no pop while busy, `mac_x`/`mac_y`=0, `done` 3 cycles late, `result`=26.
- Pulse `start` again during FEED with `cfg_len` different → ignored, and the original length completes. Then assert `reset` mid-FEED → `mac_reset` high, FIFO empty, no `done`, `result`=0.
- `WIDTH`=8, pairs (16,16),(1,1) → `result`=1 (wrap-around).
